// File: rtl/csr_pkg.sv
// Shared definitions for the CSR unit: widths, decoded CSR opcodes, CSR addresses,
// per-CSR software-writable masks, FSM state encodings and the latched request payload.
// Optional timer feature is controlled by the CSR_TIMER_EN macro in csr_unit/csr_timer.
package csr_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ALU_OP_WIDTH  = 8;
    localparam int unsigned CSR_NUM_WIDTH = 14;
    localparam int unsigned ECODE_WIDTH   = 6;

    // Decoded CSR operation codes (aluop values driven by the decoder)
    localparam logic [ALU_OP_WIDTH-1:0] EXE_CSRRD_OP   = 8'h60;
    localparam logic [ALU_OP_WIDTH-1:0] EXE_CSRWR_OP   = 8'h61;
    localparam logic [ALU_OP_WIDTH-1:0] EXE_CSRXCHG_OP = 8'h62;

    // CSR addresses
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_CRMD   = 14'h000;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_PRMD   = 14'h001;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_ESTAT  = 14'h005;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_ERA    = 14'h006;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_EENTRY = 14'h00C;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE0  = 14'h030;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE1  = 14'h031;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE2  = 14'h032;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE3  = 14'h033;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TID    = 14'h040;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TCFG   = 14'h041;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TVAL   = 14'h042;
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TICLR  = 14'h044;

    // Software-writable bits per CSR; bits outside the mask keep their value on write
    localparam logic [DATA_WIDTH-1:0] MASK_CRMD   = 32'h0000_01FF;
    localparam logic [DATA_WIDTH-1:0] MASK_PRMD   = 32'h0000_0007;
    localparam logic [DATA_WIDTH-1:0] MASK_ESTAT  = 32'h0000_0003;
    localparam logic [DATA_WIDTH-1:0] MASK_EENTRY = 32'hFFFF_FFC0;
    localparam logic [DATA_WIDTH-1:0] MASK_FULL   = 32'hFFFF_FFFF;
    localparam logic [DATA_WIDTH-1:0] MASK_TICLR  = 32'h0000_0001;

    localparam logic [DATA_WIDTH-1:0] CRMD_RESET  = 32'h0000_0008;

    // ESTAT field positions
    localparam int unsigned ESTAT_ECODE_LSB = 16;
    localparam int unsigned ESTAT_TI_BIT    = 11;

    // FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    // Request captured at acceptance and consumed in RESP
    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0]  op;
        logic [CSR_NUM_WIDTH-1:0] num;
        logic [DATA_WIDTH-1:0]    wdata;
        logic [DATA_WIDTH-1:0]    mask;
    } csr_req_t;

    // Replace only the bits selected by mask
    function automatic logic [DATA_WIDTH-1:0] csr_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: holds TCFG {InitVal[31:2], Periodic, En} and the TVAL down-counter.
// Built only when CSR_TIMER_EN is defined.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tcfg_we       TCFG write strobe (committed CSR write)
//   tcfg_wdata    new TCFG value
//   tcfg, tval    current TCFG / TVAL values
//   fire_c        combinational: counter reaches zero at the coming edge
module csr_timer
    import csr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tcfg_we,
    input  logic [DATA_WIDTH-1:0] tcfg_wdata,
    output logic [DATA_WIDTH-1:0] tcfg,
    output logic [DATA_WIDTH-1:0] tval,
    output logic                  fire_c
);

    logic                  en;
    logic                  periodic;
    logic [DATA_WIDTH-1:0] reload;

    assign en       = tcfg[0];
    assign periodic = tcfg[1];
    assign reload   = {tcfg[DATA_WIDTH-1:2], 2'b00};

    // Fire on the 1 -> 0 transition only; a zero count never wraps
    assign fire_c = en && (tval == DATA_WIDTH'(1));

    // TCFG/TVAL update: software load has priority over counting
    always_ff @(posedge clk) begin
        if (rst) begin
            tcfg <= '0;
            tval <= '0;
        end else if (tcfg_we) begin
            tcfg <= tcfg_wdata;
            if (tcfg_wdata[0]) begin
                tval <= {tcfg_wdata[DATA_WIDTH-1:2], 2'b00};
            end
        end else if (en && (tval != '0)) begin
            if (tval == DATA_WIDTH'(1)) begin
                if (periodic) begin
                    tval <= reload;
                end else begin
                    tval    <= '0;
                    tcfg[0] <= 1'b0;
                end
            end else begin
                tval <= tval - DATA_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/csr_unit.sv
// CSR responder: owns architectural CSR state, serves CSRRD/CSRWR/CSRXCHG with a
// one-cycle response, and applies exception entry / ERTN updates with a redirect pulse.
// Optional timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built when CSR_TIMER_EN is defined.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (ready drops in RESP and on excp/ertn)
//   aluop_i, csr_num_i           operation and target CSR
//   wdata_i, mask_i              write data and XCHG bit mask
//   resp_valid_o, resp_rdata_o   one-cycle response carrying the pre-write CSR value
//   excp_i, excp_ecode_i, excp_pc_i, ertn_i   exception / return commit
//   redirect_valid_o, redirect_pc_o           pipeline redirect pulse and target
//   timer_int_o                  ESTAT.IS[11]
module csr_unit
    import csr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [ALU_OP_WIDTH-1:0]  aluop_i,
    input  logic [CSR_NUM_WIDTH-1:0] csr_num_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [DATA_WIDTH-1:0]    mask_i,
    output logic                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]    resp_rdata_o,
    input  logic                     excp_i,
    input  logic [ECODE_WIDTH-1:0]   excp_ecode_i,
    input  logic [DATA_WIDTH-1:0]    excp_pc_i,
    input  logic                     ertn_i,
    output logic                     redirect_valid_o,
    output logic [DATA_WIDTH-1:0]    redirect_pc_o,
    output logic                     timer_int_o
);

    logic [0:0]               state;
    logic [0:0]               state_next;
    logic                     accept;
    logic                     commit;
    logic                     event_busy;
    csr_req_t                 req_q;

    logic [DATA_WIDTH-1:0]    crmd, prmd, estat, era, eentry;
    logic [DATA_WIDTH-1:0]    save0, save1, save2, save3, tid;

    logic [CSR_NUM_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [DATA_WIDTH-1:0]    wmask;
    logic [DATA_WIDTH-1:0]    wr_new;
    logic [DATA_WIDTH-1:0]    wr_val;

`ifdef CSR_TIMER_EN
    logic [DATA_WIDTH-1:0]    tcfg;
    logic [DATA_WIDTH-1:0]    tval;
    logic                     timer_fire;
    logic                     tcfg_we;
    logic                     ticlr_clr;
`endif

    // Exception/ERTN commit blocks new requests and discards an in-flight write
    assign event_busy  = excp_i | ertn_i;
    assign req_ready_o = (state == ST_IDLE) && !event_busy;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    accept     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
                commit     = (req_q.op != EXE_CSRRD_OP) && !event_busy;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request payload capture
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{op: aluop_i, num: csr_num_i, wdata: wdata_i, mask: mask_i};
        end
    end

    // Single read port: incoming address in IDLE, latched address in RESP
    assign rd_addr = (state == ST_RESP) ? req_q.num : csr_num_i;

    // CSR read mux and writable-bit mask; unimplemented addresses read 0 and mask 0
    always_comb begin
        rd_data = '0;
        wmask   = '0;
        case (rd_addr)
            CSR_CRMD:   begin rd_data = crmd;   wmask = MASK_CRMD;   end
            CSR_PRMD:   begin rd_data = prmd;   wmask = MASK_PRMD;   end
            CSR_ESTAT:  begin rd_data = estat;  wmask = MASK_ESTAT;  end
            CSR_ERA:    begin rd_data = era;    wmask = MASK_FULL;   end
            CSR_EENTRY: begin rd_data = eentry; wmask = MASK_EENTRY; end
            CSR_SAVE0:  begin rd_data = save0;  wmask = MASK_FULL;   end
            CSR_SAVE1:  begin rd_data = save1;  wmask = MASK_FULL;   end
            CSR_SAVE2:  begin rd_data = save2;  wmask = MASK_FULL;   end
            CSR_SAVE3:  begin rd_data = save3;  wmask = MASK_FULL;   end
            CSR_TID:    begin rd_data = tid;    wmask = MASK_FULL;   end
`ifdef CSR_TIMER_EN
            CSR_TCFG:   begin rd_data = tcfg;   wmask = MASK_FULL;   end
            CSR_TVAL:   begin rd_data = tval;   wmask = '0;          end
            CSR_TICLR:  begin rd_data = '0;     wmask = MASK_TICLR;  end
`endif
            default:    begin rd_data = '0;     wmask = '0;          end
        endcase
    end

    // Write value: WR replaces, XCHG replaces only the masked bits
    assign wr_new = (req_q.op == EXE_CSRXCHG_OP)
                  ? csr_merge(rd_data, req_q.wdata, req_q.mask)
                  : req_q.wdata;
    assign wr_val = csr_merge(rd_data, wr_new, wmask);

`ifdef CSR_TIMER_EN
    assign tcfg_we   = commit && (req_q.num == CSR_TCFG);
    assign ticlr_clr = commit && (req_q.num == CSR_TICLR) && wr_new[0];

    csr_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .tcfg_we    (tcfg_we),
        .tcfg_wdata (wr_val),
        .tcfg       (tcfg),
        .tval       (tval),
        .fire_c     (timer_fire)
    );
`endif

    // Architectural CSR state: exception beats ERTN beats software write
    always_ff @(posedge clk) begin
        if (rst) begin
            crmd   <= CRMD_RESET;
            prmd   <= '0;
            estat  <= '0;
            era    <= '0;
            eentry <= '0;
            save0  <= '0;
            save1  <= '0;
            save2  <= '0;
            save3  <= '0;
            tid    <= '0;
        end else begin
            if (excp_i) begin
                prmd[2:0] <= crmd[2:0];
                crmd[2:0] <= 3'b000;
                estat[ESTAT_ECODE_LSB +: ECODE_WIDTH] <= excp_ecode_i;
                era       <= excp_pc_i;
            end else if (ertn_i) begin
                crmd[2:0] <= prmd[2:0];
            end else if (commit) begin
                case (req_q.num)
                    CSR_CRMD:   crmd   <= wr_val;
                    CSR_PRMD:   prmd   <= wr_val;
                    CSR_ESTAT:  estat  <= wr_val;
                    CSR_ERA:    era    <= wr_val;
                    CSR_EENTRY: eentry <= wr_val;
                    CSR_SAVE0:  save0  <= wr_val;
                    CSR_SAVE1:  save1  <= wr_val;
                    CSR_SAVE2:  save2  <= wr_val;
                    CSR_SAVE3:  save3  <= wr_val;
                    CSR_TID:    tid    <= wr_val;
                    default:    ;
                endcase
            end
`ifdef CSR_TIMER_EN
            // A timer fire in the same cycle as a TICLR clear keeps the interrupt pending
            estat[ESTAT_TI_BIT] <= timer_fire | (estat[ESTAT_TI_BIT] & !ticlr_clr);
`endif
        end
    end

    // Registered response and redirect outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_o     <= 1'b0;
            resp_rdata_o     <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            resp_valid_o     <= accept;
            resp_rdata_o     <= accept ? rd_data : '0;
            redirect_valid_o <= event_busy;
            redirect_pc_o    <= excp_i ? eentry : (ertn_i ? era : '0);
        end
    end

`ifdef CSR_TIMER_EN
    assign timer_int_o = estat[ESTAT_TI_BIT];
`else
    assign timer_int_o = 1'b0;
`endif

endmodule
